// File: rtl/ram_port_arbiter_pkg.sv
// ram_arb_pkg: shared state encoding, RW codes and default widths for ram_port_arbiter.
// The WIPE state exists only when RAM_ARB_WIPE_EN is defined.
package ram_arb_pkg;
    localparam int AW_DEF = 2;
    localparam int DW_DEF = 4;
    localparam logic RW_READ = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
`ifdef RAM_ARB_WIPE_EN
        , ST_WIPE
`endif
    } state_t;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester ports, RAM control lines and status of ram_port_arbiter.
// WIPE is present only when RAM_ARB_WIPE_EN is defined.
interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          REQ0, REQ1, RW0, RW1, ACK0, ACK1;
    logic [AW-1:0] ADDR0, ADDR1, MEM_ADDR;
    logic [DW-1:0] DIN0, DIN1, DOUT0, DOUT1, MEM_DIN, MEM_DOUT;
    logic          BUSY, MEM_EN, MEM_RW;
`ifdef RAM_ARB_WIPE_EN
    logic          WIPE;
`endif
    modport slave (
        input  REQ0, REQ1, RW0, RW1, ADDR0, ADDR1, DIN0, DIN1, MEM_DOUT,
`ifdef RAM_ARB_WIPE_EN
        input  WIPE,
`endif
        output ACK0, ACK1, DOUT0, DOUT1, BUSY, MEM_EN, MEM_RW, MEM_ADDR, MEM_DIN
    );
    modport master (
        output REQ0, REQ1, RW0, RW1, ADDR0, ADDR1, DIN0, DIN1, MEM_DOUT,
`ifdef RAM_ARB_WIPE_EN
        output WIPE,
`endif
        input  ACK0, ACK1, DOUT0, DOUT1, BUSY, MEM_EN, MEM_RW, MEM_ADDR, MEM_DIN
    );
endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; o_last is the most recently granted port.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    output logic [1:0] o_gnt,
    output logic       o_last
);
    logic r_last;
    always_comb o_gnt = (i_req == 2'b11) ? (r_last ? 2'b01 : 2'b10) : i_req;
    always_ff @(posedge clk) begin
        if (rst) r_last <= 1'b1;
        else if (i_upd) r_last <= o_gnt[1];
    end
    assign o_last = r_last;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin two-port controller owning the single-port RAM control lines.
// Defining RAM_ARB_WIPE_EN adds a zero-fill sweep of the whole array triggered by WIPE.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input logic               CLK,
    input logic               CLR,
    ram_port_arbiter_if.slave bus
);
    state_t        r_state;
    logic          r_rw, r_ack0, r_ack1, r_mem_en, r_mem_rw;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_din, r_dout0, r_dout1;
    logic [1:0]    w_gnt;
    logic          w_last, w_wipe_go, w_grant;
`ifdef RAM_ARB_WIPE_EN
    logic          r_wipe_pend;
    assign w_wipe_go = r_wipe_pend;
`else
    assign w_wipe_go = 1'b0;
`endif
    assign w_grant = (r_state == ST_IDLE) && !w_wipe_go && |w_gnt;

    // After a grant, w_last names the port that owns the transaction in flight.
    rr_arb2 u_arb (
        .clk    (CLK),
        .rst    (CLR),
        .i_req  ({bus.REQ1, bus.REQ0}),
        .i_upd  (w_grant),
        .o_gnt  (w_gnt),
        .o_last (w_last)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state    <= ST_IDLE;
            r_rw       <= RW_WRITE;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_rw   <= RW_WRITE;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_dout0    <= '0;
            r_dout1    <= '0;
`ifdef RAM_ARB_WIPE_EN
            r_wipe_pend <= 1'b0;
`endif
        end else begin
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_mem_en  <= 1'b0;
            r_mem_rw  <= RW_WRITE;
            r_mem_din <= '0;
`ifdef RAM_ARB_WIPE_EN
            if (bus.WIPE && r_state != ST_WIPE) r_wipe_pend <= 1'b1;
`endif
            case (r_state)
                ST_IDLE: begin
`ifdef RAM_ARB_WIPE_EN
                    if (r_wipe_pend) begin
                        r_state    <= ST_WIPE;
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= '0;
                    end
`endif
                    if (w_grant) begin
                        r_state    <= ST_ISSUE;
                        r_mem_en   <= 1'b1;
                        r_rw       <= w_gnt[1] ? bus.RW1 : bus.RW0;
                        r_mem_rw   <= w_gnt[1] ? bus.RW1 : bus.RW0;
                        r_mem_addr <= w_gnt[1] ? bus.ADDR1 : bus.ADDR0;
                        r_mem_din  <= w_gnt[1] ? bus.DIN1 : bus.DIN0;
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                ST_WAIT: begin
                    r_state <= ST_RESP;
                    r_ack0  <= !w_last;
                    r_ack1  <= w_last;
                    if (r_rw == RW_READ && !w_last) r_dout0 <= bus.MEM_DOUT;
                    if (r_rw == RW_READ && w_last) r_dout1 <= bus.MEM_DOUT;
                end
                ST_RESP: r_state <= ST_IDLE;
`ifdef RAM_ARB_WIPE_EN
                ST_WIPE: begin
                    if (r_mem_addr == '1) begin
                        r_state     <= ST_IDLE;
                        r_wipe_pend <= 1'b0;
                    end else begin
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= r_mem_addr + 1'b1;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ACK0     = r_ack0;
    assign bus.ACK1     = r_ack1;
    assign bus.DOUT0    = r_dout0;
    assign bus.DOUT1    = r_dout1;
    assign bus.BUSY     = r_state != ST_IDLE;
    assign bus.MEM_EN   = r_mem_en;
    assign bus.MEM_RW   = r_mem_rw;
    assign bus.MEM_ADDR = r_mem_addr;
    assign bus.MEM_DIN  = r_mem_din;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench with a transaction-timeline model of ram_port_arbiter.
// Wipe scenarios run only when RAM_ARB_WIPE_EN is defined.
module tb_ram_port_arbiter;
    localparam int AW = 2;
    localparam int DW = 4;
    localparam int N = 1 << AW;

    logic clk = 1'b0, clr = 1'b1, tb_wipe = 1'b0;
    int errors = 0, checks = 0, cyc = 0;

    ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus();
    ram_port_arbiter #(.AW(AW), .DW(DW)) dut (.CLK(clk), .CLR(clr), .bus(bus));

    always #5 clk = ~clk;
`ifdef RAM_ARB_WIPE_EN
    assign bus.WIPE = tb_wipe;
`endif

    // Behavioural single-port RAM: read data appears the cycle after MEM_EN.
    logic [DW-1:0] ram [N] = '{default: '0};
    always @(posedge clk) begin
        if (bus.MEM_EN) begin
            if (bus.MEM_RW) bus.MEM_DOUT <= ram[bus.MEM_ADDR];
            else ram[bus.MEM_ADDR] <= bus.MEM_DIN;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: each grant at edge s owns the RAM for a fixed window; outputs follow from offsets to s.
    int start = -100, busy_end = 0;
    bit chk_on = 0, m_wipe = 0, m_last = 1, m_pend = 0, m_port = 0, m_rw = 0, in_wipe = 0;
    bit e_en = 0, e_rw = 0, e_ack0 = 0, e_ack1 = 0, e_busy = 0;
    logic [AW-1:0] m_addr = '0, e_addr = '0;
    logic [DW-1:0] m_din = '0, e_din = '0;
    logic [DW-1:0] m_mem [N] = '{default: '0};
    logic [DW-1:0] m_dout [2] = '{default: '0};
    always @(posedge clk) begin
        cyc++;
        if (clr) begin
            chk_on = 1; start = -100; busy_end = 0; m_wipe = 0; m_last = 1; m_pend = 0;
            m_dout = '{default: '0}; e_addr = '0;
        end else begin
            if (cyc >= busy_end && m_pend) begin
                m_wipe = 1; start = cyc; busy_end = cyc + N + 1; m_mem = '{default: '0};
            end else if (cyc >= busy_end && (bus.REQ0 || bus.REQ1)) begin
                m_port = (bus.REQ0 && bus.REQ1) ? !m_last : bus.REQ1;
                m_last = m_port; m_wipe = 0; start = cyc; busy_end = cyc + 4;
                m_rw = m_port ? bus.RW1 : bus.RW0;
                m_addr = m_port ? bus.ADDR1 : bus.ADDR0;
                m_din = m_port ? bus.DIN1 : bus.DIN0;
                if (!m_rw) m_mem[m_addr] = m_din;
            end
            in_wipe = m_wipe && cyc > start && cyc <= start + N;
            if (tb_wipe && !in_wipe) m_pend = 1;
            if (m_wipe && cyc == start + N) m_pend = 0;
            if (!m_wipe && m_rw && cyc == start + 2) m_dout[m_port] = m_mem[m_addr];
        end
        e_en = m_wipe ? (cyc >= start && cyc < start + N) : (cyc == start);
        e_rw = e_en && !m_wipe && m_rw;
        e_din = (e_en && !m_wipe) ? m_din : '0;
        if (e_en) e_addr = m_wipe ? AW'(cyc - start) : m_addr;
        e_ack0 = !m_wipe && cyc == start + 2 && !m_port;
        e_ack1 = !m_wipe && cyc == start + 2 && m_port;
        e_busy = cyc < busy_end - 1;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ack0", bus.ACK0, e_ack0);
            chk("ack1", bus.ACK1, e_ack1);
            chk("dout0", bus.DOUT0, m_dout[0]);
            chk("dout1", bus.DOUT1, m_dout[1]);
            chk("busy", bus.BUSY, e_busy);
            chk("mem_en", bus.MEM_EN, e_en);
            chk("mem_rw", bus.MEM_RW, e_rw);
            chk("mem_addr", bus.MEM_ADDR, e_addr);
            chk("mem_din", bus.MEM_DIN, e_din);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit port, output int at);
        at = -1;
        for (int n = 0; n < 40 && at < 0; n++) begin
            @(negedge clk);
            if (port ? bus.ACK1 : bus.ACK0) at = cyc;
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL ack%0d_timeout: got no ACK, expected one within 40 cycles", port);
        end
        tick();
    endtask

    task automatic txn(input bit port, input bit rw, input int addr, input int din, output int at);
        if (port) begin
            bus.REQ1 = 1; bus.RW1 = rw; bus.ADDR1 = AW'(addr); bus.DIN1 = DW'(din);
        end else begin
            bus.REQ0 = 1; bus.RW0 = rw; bus.ADDR0 = AW'(addr); bus.DIN0 = DW'(din);
        end
        wait_ack(port, at);
        if (port) bus.REQ1 = 0;
        else bus.REQ0 = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected one before 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1, t_start;
        int order[$];
        int ack_at[$];
        bus.REQ0 = 1; bus.REQ1 = 1; bus.RW0 = 0; bus.RW1 = 0;
        bus.ADDR0 = '0; bus.ADDR1 = '0; bus.DIN0 = '0; bus.DIN1 = '0;
        clr = 1;
        tick();
        tick();
        chk("rst_ack0", bus.ACK0, 0);
        chk("rst_ack1", bus.ACK1, 0);
        chk("rst_dout0", bus.DOUT0, 0);
        chk("rst_dout1", bus.DOUT1, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_mem_en", bus.MEM_EN, 0);
        chk("rst_mem_addr", bus.MEM_ADDR, 0);
        clr = 0; bus.REQ0 = 0; bus.REQ1 = 0;
        tick();

        t_start = cyc;
        txn(0, 0, 2, 'hA, t0);
        chk("wr_latency", t0 - t_start, 3);
        chk("wr_ram2", ram[2], 'hA);
        txn(0, 1, 2, 0, t1);
        chk("rd_dout0", bus.DOUT0, 'hA);
        chk("rd_dout1", bus.DOUT1, 0);

        clr = 1;
        tick();
        clr = 0;
        t_start = cyc;
        bus.REQ0 = 1; bus.RW0 = 0; bus.ADDR0 = 1; bus.DIN0 = 5;
        bus.REQ1 = 1; bus.RW1 = 1; bus.ADDR1 = 2; bus.DIN1 = 3;
        for (int n = 0; n < 60 && order.size() < 4; n++) begin
            @(negedge clk);
            if (bus.ACK0) begin order.push_back(0); ack_at.push_back(cyc); end
            if (bus.ACK1) begin order.push_back(1); ack_at.push_back(cyc); end
        end
        tick();
        bus.REQ0 = 0; bus.REQ1 = 0;
        chk("cont_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) chk($sformatf("cont_grant%0d", i), order[i], i % 2);
        if (ack_at.size() > 0) chk("cont_first_ack", ack_at[0] - t_start, 3);
        for (int i = 1; i < ack_at.size(); i++) chk($sformatf("cont_gap%0d", i), ack_at[i] - ack_at[i-1], 4);
        chk("cont_dout1", bus.DOUT1, 'hA);
        chk("cont_ram1", ram[1], 5);

        bus.REQ1 = 1; bus.RW1 = 1; bus.ADDR1 = 2;
        tick();
        tick();
        clr = 1; bus.REQ1 = 0;
        tick();
        clr = 0;
        chk("rmo_ack1", bus.ACK1, 0);
        chk("rmo_dout1", bus.DOUT1, 0);
        chk("rmo_busy", bus.BUSY, 0);
        tick();
        chk("rmo_idle", bus.BUSY, 0);
        chk("rmo_ack1_late", bus.ACK1, 0);

`ifdef RAM_ARB_WIPE_EN
        for (int a = 0; a < N; a++) txn(1'(a % 2), 0, a, 'hF, t0);
        txn(0, 1, 0, 0, t0);
        txn(1, 1, 3, 0, t0);
        chk("pre_wipe_dout0", bus.DOUT0, 'hF);
        chk("pre_wipe_dout1", bus.DOUT1, 'hF);
        tb_wipe = 1;
        tick();
        tb_wipe = 0;
        repeat (N + 2) tick();
        for (int a = 0; a < N; a++) chk($sformatf("wipe_ram%0d", a), ram[a], 0);
        for (int a = 0; a < N; a++) begin
            txn(1'(a % 2), 1, a, 0, t0);
            chk($sformatf("wipe_rd%0d", a), (a % 2) ? bus.DOUT1 : bus.DOUT0, 0);
        end

        t_start = cyc;
        bus.REQ0 = 1; bus.RW0 = 0; bus.ADDR0 = 1; bus.DIN0 = 7;
        tick();
        tb_wipe = 1; bus.REQ1 = 1; bus.RW1 = 1; bus.ADDR1 = 1;
        tick();
        tb_wipe = 0;
        wait_ack(0, t0);
        bus.REQ0 = 0;
        wait_ack(1, t1);
        bus.REQ1 = 0;
        chk("wt_ack0_lat", t0 - t_start, 3);
        chk("wt_ack1_gap", t1 - t0, 9);
        chk("wt_dout1", bus.DOUT1, 0);
        chk("wt_ram1", ram[1], 0);
`endif
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester controller for the team's small synchronous single-port RAM. It arbitrates round-robin between two request ports and sequences each access: issue, read-data wait and response. It optionally runs a zero-fill sweep of the whole array. It sits between the requesting datapaths and the RAM instance and owns every RAM control line.

## Interface
- AW, 2, RAM address width (depth 2^AW)
- DW, 4, RAM data width
- CLK  in  1  clock, all logic on rising edge
- CLR  in  1  reset, synchronous, active-high
- REQ0 / REQ1  in  1  request; held high with fields stable until matching ACK
- RW0 / RW1  in  1  1 = read, 0 = write
- ADDR0 / ADDR1  in  AW  access address
- DIN0 / DIN1  in  DW  write data
- ACK0 / ACK1  out  1  one-cycle completion pulse
- DOUT0 / DOUT1  out  DW  read data, registered, valid with ACK, held until the next read by the same port
- WIPE  in  1  zero-fill request pulse (only with RAM_ARB_WIPE_EN)
- BUSY  out  1  high whenever state != IDLE
- MEM_EN  out  1  RAM access strobe, one cycle per access
- MEM_RW  out  1  1 = read, 0 = write
- MEM_ADDR  out  AW  RAM address
- MEM_DIN  out  DW  RAM write data
- MEM_DOUT  in  DW  RAM read data, valid the cycle after MEM_EN

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP, plus WIPE when RAM_ARB_WIPE_EN is defined.
- IDLE: evaluates at each edge, in priority order:
  - pending wipe → WIPE
  - else any REQ → latch the granted port's RW/ADDR/DIN → ISSUE
  - else stay in IDLE
- ISSUE: MEM_EN=1 with MEM_RW/MEM_ADDR/MEM_DIN from the latched request → WAIT.
- WAIT: MEM_EN=0. For a read, MEM_DOUT is captured into the granted port's DOUT at the end of this cycle. → RESP.
- RESP: ACK of the granted port = 1 → IDLE. A requester drops REQ on the edge ending RESP; a REQ still high in the following IDLE is a new request.
- Arbitration is round-robin via a LAST register (reset value 1, so port 0 wins the first tie):
  - One requester only: it is granted.
  - Both requesting: the port other than LAST is granted.
  - LAST is updated on every grant.
- Write transactions do not alter DOUTn.
- With both ports held requesting, grants alternate 0,1,0,1…

## Timing
- Reset values (CLR sampled high): state IDLE, all ACK 0, DOUT0 = DOUT1 = 0, MEM_EN 0, MEM_RW 0, MEM_ADDR 0, MEM_DIN 0, BUSY 0, LAST 1, wipe-pending 0.
- CLR mid-transaction: the transaction is abandoned with no ACK and no further MEM_EN. CLR overrides all other inputs in the same cycle.
- Latency: REQ high in IDLE cycle t → MEM_EN in t+1 → DOUT updated and ACK high in t+3.
- Throughput: one transaction per 4 cycles.
- MEM_* outputs are registered. They are zero whenever MEM_EN = 0, except MEM_ADDR, which holds its last value.

## Configuration
- Macro RAM_ARB_WIPE_EN.
- Defined:
  - WIPE port exists. A WIPE pulse in any state sets wipe-pending.
  - From IDLE, the WIPE state writes 0 to addresses 0 … 2^AW−1, one per cycle: MEM_EN=1, MEM_RW=0, MEM_DIN=0, ascending address.
  - After the last address the FSM returns to IDLE and clears pending.
  - Wipe has priority over requests in IDLE. An in-flight transaction completes normally before the wipe starts.
  - A WIPE pulse during WIPE is ignored.
- Undefined: no WIPE port, no WIPE state, no address counter.

## Structure
- Package ram_arb_pkg holds:
  - state enum
  - RW_READ = 1, RW_WRITE = 0
  - default AW/DW localparams
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], update strobe.
  - Outputs: gnt[1:0] one-hot, LAST register.

## Test plan
- Reset: hold CLR 2 cycles with REQ0 = REQ1 = 1 → all outputs 0, BUSY 0, no MEM_EN.
- Write then read: REQ0 write ADDR0=2, DIN0=4'hA → MEM_EN=1, MEM_RW=0, MEM_ADDR=2, MEM_DIN=A at t+1, ACK0 at t+3. Then REQ0 read ADDR0=2 → ACK0 with DOUT0=4'hA; DOUT1 stays 0.
- Contention: REQ0 and REQ1 rise together after reset and stay high → grant order 0,1,0,1. Each ACK is exactly 4 cycles after the previous one.
- Reset mid-operation: CLR asserted in WAIT of a port-1 read → no ACK1, DOUT1 = 0, IDLE next cycle.
- Wipe (macro on): write 4'hF to addresses 0–3, then pulse WIPE → addresses 0,1,2,3 written with 0 on 4 consecutive cycles, BUSY high throughout. Subsequent reads of each address return 0.
- Wipe during transaction (macro on): pulse WIPE in ISSUE of a port-0 write → ACK0 still issued, wipe starts in the cycle after the return to IDLE, and a pending REQ1 waits until the wipe ends.
